// File: rtl/bp_be_pkg.sv
// Shared back-end definitions for the scoreboard clear path: the clear entry
// layout and the macro that gives its width for a given register address width.
`define BP_BE_CLEAR_ENTRY_WIDTH(addr_w) (addr_w)

package bp_be_pkg;

  localparam int reg_addr_width_gp = 5;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
  } bp_be_clear_entry_s;

endpackage

// File: rtl/bp_be_clear_seq_fifo.sv
// Two-write / one-read circular buffer of pending clear rd values with occupancy count.
// Under BP_BE_CLEAR_SEQ_COALESCE_EN it also exposes every slot and its valid bit.
module bp_be_clear_seq_fifo
  import bp_be_pkg::*;
#(
  parameter int els_p    = 4,
  parameter int addr_w_p = 5,
  localparam int width_lp = `BP_BE_CLEAR_ENTRY_WIDTH(addr_w_p),
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                w0_v_i,
  input  logic [width_lp-1:0] w0_data_i,
  input  logic                w1_v_i,
  input  logic [width_lp-1:0] w1_data_i,
  input  logic                yumi_i,
  output logic                v_o,
  output logic [width_lp-1:0] data_o,
`ifdef BP_BE_CLEAR_SEQ_COALESCE_EN
  output logic [els_p-1:0][width_lp-1:0] entries_o,
  output logic [els_p-1:0]               entry_v_o,
`endif
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_lp-1:0] mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d, w1_addr;
  logic [cnt_w_lp-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q + ptr_w_lp'(w0_v_i) + ptr_w_lp'(w1_v_i);
    rptr_d  = rptr_q + ptr_w_lp'(yumi_i);
    count_d = count_q + cnt_w_lp'(w0_v_i) + cnt_w_lp'(w1_v_i) - cnt_w_lp'(yumi_i);
    // The second port lands behind the first when both write in one cycle.
    w1_addr = w0_v_i ? wptr_q + ptr_w_lp'(1) : wptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w0_v_i) mem_q[wptr_q]  <= w0_data_i;
    if (w1_v_i) mem_q[w1_addr] <= w1_data_i;
  end

  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

`ifdef BP_BE_CLEAR_SEQ_COALESCE_EN
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      entries_o[i] = mem_q[i];
      entry_v_o[i] = cnt_w_lp'(ptr_w_lp'(i) - rptr_q) < count_q;
    end
  end
`endif

endmodule

// File: rtl/bp_be_clear_sequencer.sv
// Buffers long-latency writeback completions (mem fill, long op) and emits one
// scoreboard clear per cycle in acceptance order. Optional: BP_BE_CLEAR_SEQ_COALESCE_EN.
module bp_be_clear_sequencer
  import bp_be_pkg::*;
#(
  parameter int fifo_els_p       = 4,
  parameter int reg_addr_width_p = 5,
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mem_v_i,
  input  logic [reg_addr_width_p-1:0] mem_rd_i,
  output logic                        mem_ready_and_o,
  input  logic                        long_v_i,
  input  logic [reg_addr_width_p-1:0] long_rd_i,
  output logic                        long_ready_and_o,
  output logic                        clear_v_o,
  output logic [reg_addr_width_p-1:0] clear_rd_o,
  input  logic                        clear_ready_and_i,
  output logic [cnt_w_lp-1:0]         pending_o,
  output logic                        empty_o
);

  logic [cnt_w_lp-1:0]         count;
  logic [cnt_w_lp:0]           free;
  logic                        mem_acc, long_acc, mem_enq, long_enq;
  logic                        fifo_v, yumi;
  logic [reg_addr_width_p-1:0] fifo_rd;

`ifdef BP_BE_CLEAR_SEQ_COALESCE_EN
  logic [fifo_els_p-1:0][reg_addr_width_p-1:0] entries;
  logic [fifo_els_p-1:0]                       entry_v;
  logic                                        mem_hit, long_hit;
`endif

  // Space is judged on registered count only; a same-cycle pop never credits a slot.
  always_comb begin
    free             = (cnt_w_lp+1)'(fifo_els_p) - {1'b0, count};
    mem_ready_and_o  = ~reset_i & (free >= (cnt_w_lp+1)'(1));
    mem_acc          = mem_v_i & mem_ready_and_o;
    long_ready_and_o = ~reset_i & (free >= ((cnt_w_lp+1)'(1) + (cnt_w_lp+1)'(mem_acc)));
    long_acc         = long_v_i & long_ready_and_o;
`ifdef BP_BE_CLEAR_SEQ_COALESCE_EN
    mem_hit  = 1'b0;
    long_hit = 1'b0;
    for (int i = 0; i < fifo_els_p; i++) begin
      mem_hit  = mem_hit  | (entry_v[i] & (entries[i] == mem_rd_i));
      long_hit = long_hit | (entry_v[i] & (entries[i] == long_rd_i));
    end
    mem_enq  = mem_acc & (mem_rd_i != '0) & ~mem_hit;
    long_enq = long_acc & (long_rd_i != '0) & ~long_hit
             & ~(mem_enq & (mem_rd_i == long_rd_i));
`else
    mem_enq  = mem_acc & (mem_rd_i != '0);
    long_enq = long_acc & (long_rd_i != '0);
`endif
  end

  bp_be_clear_seq_fifo #(
    .els_p    (fifo_els_p),
    .addr_w_p (reg_addr_width_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .w0_v_i    (mem_enq),
    .w0_data_i (mem_rd_i),
    .w1_v_i    (long_enq),
    .w1_data_i (long_rd_i),
    .yumi_i    (yumi),
    .v_o       (fifo_v),
    .data_o    (fifo_rd),
`ifdef BP_BE_CLEAR_SEQ_COALESCE_EN
    .entries_o (entries),
    .entry_v_o (entry_v),
`endif
    .count_o   (count)
  );

  assign clear_v_o  = fifo_v;
  assign clear_rd_o = fifo_v ? fifo_rd : '0;
  assign yumi       = fifo_v & clear_ready_and_i;
  assign pending_o  = count;
  assign empty_o    = ~fifo_v;

endmodule

// File: doc/bp_be_clear_sequencer.md
Name: bp_be_clear_sequencer

Overview:
- Producer side of the dual-issue scoreboard clear path.
- Collects register-writeback completions from two long-latency sources (D$ miss fill, long-op unit: div/fdiv/sqrt) and buffers them.
- Emits at most one clear (valid + rd address) per cycle toward the scoreboard's single clear port.
- Sits between the long-latency returns and the scoreboard, alongside the writeback arbitration.

Parameters:
- fifo_els_p, 4, pending-clear buffer depth; power of 2, ≥2.
- reg_addr_width_p, 5, architectural register address width (matches reg_addr_width_gp).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- mem_v_i  in  1  D$ miss-fill completion valid.
- mem_rd_i  in  reg_addr_width_p  rd of the mem completion.
- mem_ready_and_o  out  1  mem completion accepted when mem_v_i & mem_ready_and_o.
- long_v_i  in  1  long-op completion valid.
- long_rd_i  in  reg_addr_width_p  rd of the long-op completion.
- long_ready_and_o  out  1  long completion accepted when long_v_i & long_ready_and_o.
- clear_v_o  out  1  clear request to scoreboard.
- clear_rd_o  out  reg_addr_width_p  rd to clear.
- clear_ready_and_i  in  1  scoreboard/writeback port accepts the clear this cycle.
- pending_o  out  $clog2(fifo_els_p+1)  entries currently buffered.
- empty_o  out  1  no pending clears.

Behaviour:
- Reset, asynchronous, active-high:
  - Buffer emptied; clear_v_o=0, clear_rd_o=0, pending_o=0, empty_o=1.
  - Readies go 1 once reset deasserts.
  - Reset mid-operation discards all pending entries with no clear emitted.
- Storage: circular buffer of fifo_els_p entries; rd fields only.
  - Read/write pointers are $clog2(fifo_els_p) bits and wrap naturally.
  - Count register is $clog2(fifo_els_p+1) bits.
- Free space: free = fifo_els_p − count, computed from registered count only.
  - A dequeue in the same cycle does not credit space; no full-bypass path.
- Ready rules:
  - mem_ready_and_o = (free ≥ 1).
  - long_ready_and_o = (free ≥ 1 + (mem_v_i & mem_ready_and_o)).
  - long ready therefore has a combinational dependence on mem_v_i; sources must not make valid depend on ready.
- Enqueue order:
  - On a same-cycle double accept, the mem entry is written first, then the long entry.
  - Up to two writes per cycle.
- rd = x0: completion is accepted (ready honoured) but not enqueued, and count does not change. Applies per source independently.
- Output:
  - clear_v_o = !empty; clear_rd_o = head entry; both driven from registered state.
  - Minimum latency, accept to clear_v_o, is 1 cycle.
  - A handshake (clear_v_o & clear_ready_and_i) pops one entry.
- Count update: count_n = count + enq_cnt(0..2) − deq(0/1).
  - Simultaneous enqueue and dequeue on a full buffer: dequeue pops, enqueues are blocked by ready (no overflow).
  - With 1 free slot and both valid: mem accepted, long stalled.
- Order preserved: clears leave in acceptance order.
- clear_rd_o holds stable while clear_v_o=1 and not accepted.

Optional Feature:
- BP_BE_CLEAR_SEQ_COALESCE_EN defined:
  - If mem and long are accepted in the same cycle with equal nonzero rd, only one entry is enqueued (count +1).
  - An incoming rd equal to any valid buffered entry is accepted but not enqueued.
  - Requires a fifo_els_p-wide compare.
- Undefined: every accepted nonzero rd is enqueued, duplicates included.

Decomposition:
- bp_be_pkg: clear entry struct (rd field) and its width macro.
- Sub-module bp_be_clear_seq_fifo: 2-write/1-read circular buffer with count, separate write enables, ordered writes.
- Top module holds the ready logic, x0 filtering and the optional coalescing.

Test Plan:
- Reset: assert reset_i asynchronously mid-cycle with 3 entries pending → clear_v_o=0, pending_o=0, empty_o=1 immediately; no further clears.
- Single completion: mem_v_i=1, rd=7 at cycle 0 → clear_v_o=1, clear_rd_o=7 at cycle 1; with clear_ready_and_i=1, empty_o=1 at cycle 2.
- Same-cycle pair: mem rd=3, long rd=9, clear_ready_and_i=0 → pending_o=2; then release ready → clears 3, then 9 on consecutive cycles.
- Full/backpressure:
  - Fill 4 entries, hold clear_ready_and_i=0 → both readies 0.
  - Pop one → next cycle mem_ready=1; with both valid, long_ready=0, mem enqueued; pointers wrap correctly.
- x0 filter: long_v_i=1, rd=0 → long_ready_and_o=1, pending_o unchanged, no clear.
- Coalesce, macro on: mem rd=5 and long rd=5 together → pending_o=1, single clear of 5. Macro off → two clears of 5.
